md_arbiter: RTL and testbench
=============================

# md_arbiter

Two-port round-robin arbiter and sequencer for the shared mul/div unit. It accepts M-extension operations from two requesters, such as the integer pipeline and a debug/accelerator port, and issues one operation at a time to the mul/div unit. It holds the operands and function code stable for the entire operation, captures the result once the unit is no longer busy, and returns the result to the originating port through a one-entry response buffer per port.

## Interface
**Parameters**
- `EN_CYCLES`, default 1 — cycles `o_md_en` is held per issue. Use 1 without the mul/div input register and 2 with it. Legal values are 1 and 2.

**Ports**
- `i_clk_n` in 1 — clock; all state updates on its rising edge.
- `i_rst` in 1 — reset, synchronous, active-high.
- `i_req0_valid`, `i_req1_valid` in 1 — request valid.
- `i_req0_a`, `i_req1_a` in 32 — operand A.
- `i_req0_b`, `i_req1_b` in 32 — operand B.
- `i_req0_funct3`, `i_req1_funct3` in 3 — M-extension funct3.
- `o_req0_ready`, `o_req1_ready` out 1 — request accepted this cycle (combinational).
- `o_rsp0_valid`, `o_rsp1_valid` out 1 — response buffer full.
- `o_rsp0_result`, `o_rsp1_result` out 32 — buffered result.
- `i_rsp0_ready`, `i_rsp1_ready` in 1 — response consumed.
- `o_md_a`, `o_md_b` out 32 — operands to the mul/div unit.
- `o_md_funct3` out 3 — function code to the mul/div unit.
- `o_md_en` out 1 — mul/div enable.
- `i_md_result` in 32 — mul/div result (combinational from the held inputs).
- `i_md_busy` in 1 — mul/div busy.
- `o_busy` out 1 — FSM not in IDLE.

## Operation
**FSM states:** IDLE, ISSUE, WAIT.

**IDLE**
- Port p is eligible when `i_reqp_valid` is high and `o_rspp_valid` is low.
- If one port is eligible, it is granted. If both are eligible, the port not granted most recently is granted. The last-grant pointer resets to 1, so port 0 wins the first tie.
- `o_reqp_ready` = IDLE && grant == p.
- On accept:
  - latch A, B, and funct3 into the `o_md_*` registers;
  - record the owner;
  - update the last-grant pointer;
  - load the issue counter with `EN_CYCLES`−1;
  - go to ISSUE.

**ISSUE**
- `o_md_en` = 1.
- The counter decrements each cycle.
- When the counter is 0, go to WAIT.

**WAIT**
- `o_md_en` = 0.
- `o_md_a`, `o_md_b`, and `o_md_funct3` stay unchanged, because the unit's sign post-processing reads them live.
- In the first WAIT cycle and every later one: if `i_md_busy` is 0, write `i_md_result` into the owner's response buffer, set `o_rsp<owner>_valid`, and go to IDLE.
- `i_md_busy` is never sampled during ISSUE.

**Response buffers**
- Each buffer clears when valid && `i_rspp_ready`.
- A buffer being drained in the current cycle still blocks eligibility in that cycle.
- A capture and a drain never target the same full buffer, because a port with a full buffer cannot be granted.

**Registers and reset**
- The `o_md_*` registers hold their values in IDLE (no toggling).
- Reset values:
  - FSM = IDLE;
  - all `o_md_*` = 0;
  - `o_md_en` = 0;
  - `o_rsp*_valid` = 0;
  - `o_rsp*_result` = 0;
  - `o_busy` = 0;
  - last-grant pointer = 1.
- Reset mid-operation abandons the operation: no response is produced, and the mul/div unit receives the same reset.

## Timing
- With the accept in cycle N, `o_md_en` is high in cycles N+1 … N+`EN_CYCLES`.
- The first WAIT cycle is N+`EN_CYCLES`+1.
- If busy is low in WAIT cycle W, `o_rspp_valid` is high from cycle W+1, and IDLE can accept in cycle W+1.
- Minimum accept-to-response latency is `EN_CYCLES`+2 cycles. This applies to the fast multiplier, and to the sequential multiplier with B=0.
- The divider takes ≈32 additional cycles.
- Back-to-back throughput: one new accept per operation, starting in the cycle the response becomes valid.
- `o_req*_ready` is never high outside IDLE.
- At most one ready is high per cycle.

## Test plan
- **DIVU:** port 0 sends A=100, B=7, funct3=101 → `o_rsp0_result`=14. `o_md_en` is high exactly `EN_CYCLES` cycles, and the operands stay stable until capture.
- **Signed REM:** port 1 sends A=0xFFFFFFF9 (−7), B=2, funct3=110 → `o_rsp1_result`=0xFFFFFFFF.
- **Simultaneous requests:** both ports request MULHU 0xFFFFFFFF×0xFFFFFFFF (funct3=011) in the same cycle after reset.
  - Port 0 is granted first, then port 1.
  - Both results are 0xFFFFFFFE.
  - On the next tie, port 0 is granted again.
- **Response backpressure:** hold `i_rsp0_ready`=0 after a port 0 MUL 3×5 (result 15).
  - A further port 0 request is not accepted; a port 1 request is accepted meanwhile.
  - Asserting `i_rsp0_ready` clears the buffer, and the port 0 request is accepted the cycle after.
- **MUL with B=0** (busy never rises) → response is 0 at minimum latency, and the FSM returns to IDLE.
- **Reset mid-operation:** assert `i_rst` during a divide's WAIT.
  - All outputs go to their reset values the next cycle, and no `o_rsp*_valid` appears.
  - A subsequent DIVU 9/3 returns 3.

Source files
------------

// File: rtl/md_arbiter.sv
// rtl/md_arbiter.sv - two-port round-robin arbiter and sequencer for the shared mul/div unit
//
// Ports:
//   i_clk_n                    clock, all state updates on its rising edge
//   i_rst                      synchronous active-high reset
//   i_req<p>_valid/_a/_b/_funct3  operation request from port p
//   o_req<p>_ready             request of port p accepted this cycle
//   o_rsp<p>_valid/_result     one-entry response buffer of port p
//   i_rsp<p>_ready             response of port p consumed
//   o_md_a/_b/_funct3          operands and function code held for the mul/div unit
//   o_md_en                    mul/div enable, high for EN_CYCLES cycles per issue
//   i_md_result, i_md_busy     mul/div result (live from held operands) and busy
//   o_busy                     an operation is being issued or awaited
module md_arbiter #(
  parameter int EN_CYCLES = 1
) (
  input  logic        i_clk_n,
  input  logic        i_rst,

  input  logic        i_req0_valid,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic [2:0]  i_req0_funct3,
  output logic        o_req0_ready,

  input  logic        i_req1_valid,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  input  logic [2:0]  i_req1_funct3,
  output logic        o_req1_ready,

  output logic        o_rsp0_valid,
  output logic [31:0] o_rsp0_result,
  input  logic        i_rsp0_ready,

  output logic        o_rsp1_valid,
  output logic [31:0] o_rsp1_result,
  input  logic        i_rsp1_ready,

  output logic [31:0] o_md_a,
  output logic [31:0] o_md_b,
  output logic [2:0]  o_md_funct3,
  output logic        o_md_en,
  input  logic [31:0] i_md_result,
  input  logic        i_md_busy,

  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] CNT_LOAD = 2'(EN_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  issue_cnt;
  logic        last_grant;
  logic        owner;

  logic        elig0;
  logic        elig1;
  logic        grant;
  logic        accept;
  logic        capture;

  // A full response buffer blocks its port, even while it is being drained,
  // so a capture can never land on a buffer that still holds data.
  always_comb begin
    elig0  = i_req0_valid & ~o_rsp0_valid;
    elig1  = i_req1_valid & ~o_rsp1_valid;
    // On a tie the port that was not granted last wins; otherwise the
    // single eligible port is chosen.
    grant  = (elig0 & elig1) ? ~last_grant : elig1;
    accept = (state == S_IDLE) & (elig0 | elig1);
    o_req0_ready = accept & ~grant;
    o_req1_ready = accept &  grant;
  end

  // Busy is only meaningful once the unit has seen the enable, so it is
  // looked at in WAIT and never in ISSUE.
  assign capture = (state == S_WAIT) & ~i_md_busy;

  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_md_en   = 1'b0;
    o_busy    = 1'b1;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (accept) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_md_en = 1'b1;
        if (issue_cnt == 2'd0) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!i_md_busy) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand registers load only on accept and otherwise hold, because the
  // unit's sign post-processing reads them live until the result is taken.
  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      o_md_a      <= '0;
      o_md_b      <= '0;
      o_md_funct3 <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      issue_cnt   <= '0;
    end else begin
      if (accept) begin
        o_md_a      <= grant ? i_req1_a      : i_req0_a;
        o_md_b      <= grant ? i_req1_b      : i_req0_b;
        o_md_funct3 <= grant ? i_req1_funct3 : i_req0_funct3;
        owner       <= grant;
        last_grant  <= grant;
        issue_cnt   <= CNT_LOAD;
      end else if ((state == S_ISSUE) && (issue_cnt != 2'd0)) begin
        issue_cnt <= issue_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      o_rsp0_valid  <= 1'b0;
      o_rsp0_result <= '0;
    end else if (capture && !owner) begin
      o_rsp0_valid  <= 1'b1;
      o_rsp0_result <= i_md_result;
    end else if (o_rsp0_valid && i_rsp0_ready) begin
      o_rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      o_rsp1_valid  <= 1'b0;
      o_rsp1_result <= '0;
    end else if (capture && owner) begin
      o_rsp1_valid  <= 1'b1;
      o_rsp1_result <= i_md_result;
    end else if (o_rsp1_valid && i_rsp1_ready) begin
      o_rsp1_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_md_arbiter.sv
// tb/tb_md_arbiter.sv - self-checking bench for md_arbiter
module tb_md_arbiter;

  localparam int EN = 2;

  logic        i_clk_n = 1'b0;
  logic        i_rst;
  logic        i_req0_valid, i_req1_valid;
  logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic [2:0]  i_req0_funct3, i_req1_funct3;
  logic        o_req0_ready, o_req1_ready;
  logic        o_rsp0_valid, o_rsp1_valid;
  logic [31:0] o_rsp0_result, o_rsp1_result;
  logic        i_rsp0_ready, i_rsp1_ready;
  logic [31:0] o_md_a, o_md_b;
  logic [2:0]  o_md_funct3;
  logic        o_md_en;
  logic [31:0] i_md_result;
  logic        i_md_busy;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  md_arbiter #(.EN_CYCLES(EN)) dut (
    .i_clk_n(i_clk_n), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
    .i_req0_funct3(i_req0_funct3), .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
    .i_req1_funct3(i_req1_funct3), .o_req1_ready(o_req1_ready),
    .o_rsp0_valid(o_rsp0_valid), .o_rsp0_result(o_rsp0_result), .i_rsp0_ready(i_rsp0_ready),
    .o_rsp1_valid(o_rsp1_valid), .o_rsp1_result(o_rsp1_result), .i_rsp1_ready(i_rsp1_ready),
    .o_md_a(o_md_a), .o_md_b(o_md_b), .o_md_funct3(o_md_funct3), .o_md_en(o_md_en),
    .i_md_result(i_md_result), .i_md_busy(i_md_busy), .o_busy(o_busy)
  );

  always #5 i_clk_n = ~i_clk_n;
  always @(posedge i_clk_n) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] md_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f);
    logic [63:0] ua, ub, sxa, sxb, p;
    logic signed [31:0] q;
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sxa = {{32{a[31]}}, a};
    sxb = {{32{b[31]}}, b};
    case (f)
      3'd0: begin p = ua * ub;   return p[31:0];  end
      3'd1: begin p = sxa * sxb; return p[63:32]; end
      3'd2: begin p = sxa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;   return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Behavioural mul/div unit: dividers run 32 cycles, multipliers 3 unless B is 0.
  function automatic int lat_of(input logic [2:0] f, input logic [31:0] b);
    if (f[2]) return 32;
    return (b == 0) ? 0 : 3;
  endfunction

  int busy_cnt = 0;
  always @(posedge i_clk_n) begin
    if (i_rst)                busy_cnt <= 0;
    else if (o_md_en)         busy_cnt <= lat_of(o_md_funct3, o_md_b);
    else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
  end
  assign i_md_busy   = (busy_cnt != 0);
  assign i_md_result = i_md_busy ? 32'hDEADBEEF : md_ref(o_md_a, o_md_b, o_md_funct3);

  // Transaction-level reference: one operation in flight, finishing at
  // accept + EN + 2 + unit latency, with round-robin choice on ties.
  bit          m_busy;
  int          m_owner, m_acc, m_done;
  logic [31:0] m_exp;
  bit          m_last;
  bit   [1:0]  m_bv;
  logic [31:0] m_br [2];
  logic [31:0] h_a, h_b;
  logic [2:0]  h_f;
  bit          e0, e1, g, r0, r1;

  always @(negedge i_clk_n) begin
    if (i_rst) begin
      m_busy = 0; m_last = 1; m_bv = 2'b00;
      m_br[0] = 0; m_br[1] = 0;
      h_a = 0; h_b = 0; h_f = 0;
    end else begin
      if (m_busy && cyc == m_done) begin
        m_busy = 0;
        m_bv[m_owner] = 1'b1;
        m_br[m_owner] = m_exp;
      end
      check("m_busy", o_busy, m_busy);
      check("m_md_en", o_md_en, m_busy && cyc > m_acc && cyc <= m_acc + EN);
      check("m_md_a", o_md_a, h_a);
      check("m_md_b", o_md_b, h_b);
      check("m_md_funct3", o_md_funct3, h_f);
      check("m_rsp0_valid", o_rsp0_valid, m_bv[0]);
      check("m_rsp1_valid", o_rsp1_valid, m_bv[1]);
      check("m_rsp0_result", o_rsp0_result, m_br[0]);
      check("m_rsp1_result", o_rsp1_result, m_br[1]);
      e0 = i_req0_valid && !m_bv[0];
      e1 = i_req1_valid && !m_bv[1];
      if (e0 && e1) g = (m_last == 1'b1) ? 1'b0 : 1'b1;
      else          g = e1;
      r0 = !m_busy && (e0 || e1) && (g == 1'b0);
      r1 = !m_busy && (e0 || e1) && (g == 1'b1);
      check("m_req0_ready", o_req0_ready, r0);
      check("m_req1_ready", o_req1_ready, r1);
      if (r0 || r1) begin
        h_a = g ? i_req1_a : i_req0_a;
        h_b = g ? i_req1_b : i_req0_b;
        h_f = g ? i_req1_funct3 : i_req0_funct3;
        m_busy = 1; m_owner = g ? 1 : 0; m_acc = cyc; m_last = g;
        m_done = cyc + EN + 2 + lat_of(h_f, h_b);
        m_exp  = md_ref(h_a, h_b, h_f);
      end
      if (m_bv[0] && i_rsp0_ready) m_bv[0] = 1'b0;
      if (m_bv[1] && i_rsp1_ready) m_bv[1] = 1'b0;
    end
  end

  task automatic drive_req(input int p, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] f);
    if (p == 0) begin
      i_req0_valid = v; i_req0_a = a; i_req0_b = b; i_req0_funct3 = f;
    end else begin
      i_req1_valid = v; i_req1_a = a; i_req1_b = b; i_req1_funct3 = f;
    end
  endtask

  task automatic send(input string tag, input int p, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] f, output int acc);
    bit got = 0;
    acc = -1;
    @(posedge i_clk_n); #1;
    drive_req(p, 1'b1, a, b, f);
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge i_clk_n);
      if ((p == 0) ? o_req0_ready : o_req1_ready) begin
        got = 1; acc = cyc;
      end
    end
    check({tag, "_accepted"}, got, 1);
    @(posedge i_clk_n); #1;
    drive_req(p, 1'b0, 0, 0, 0);
  endtask

  task automatic wait_rsp(input string tag, input int p, input logic [31:0] exp, output int when);
    bit got = 0;
    when = -1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge i_clk_n);
      if ((p == 0) ? o_rsp0_valid : o_rsp1_valid) begin
        got = 1; when = cyc;
        check(tag, (p == 0) ? o_rsp0_result : o_rsp1_result, exp);
      end
    end
    check({tag, "_seen"}, got, 1);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int  acc, t, encount;
  bit  got, seen;

  initial begin
    i_rst = 1'b1;
    drive_req(0, 1'b0, 0, 0, 0);
    drive_req(1, 1'b0, 0, 0, 0);
    i_rsp0_ready = 1'b1;
    i_rsp1_ready = 1'b1;
    repeat (3) @(posedge i_clk_n);
    #1 i_rst = 1'b0;

    @(negedge i_clk_n);
    check("rst_md_a", o_md_a, 0);
    check("rst_md_funct3", o_md_funct3, 0);
    check("rst_md_en", o_md_en, 0);
    check("rst_busy", o_busy, 0);
    check("rst_rsp0_valid", o_rsp0_valid, 0);
    check("rst_rsp1_result", o_rsp1_result, 0);

    // Tie straight after reset: port 0 first, port 1 in the response cycle.
    @(posedge i_clk_n); #1;
    drive_req(0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011);
    drive_req(1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011);
    @(negedge i_clk_n);
    check("tie_ready0", o_req0_ready, 1);
    check("tie_ready1", o_req1_ready, 0);
    @(posedge i_clk_n); #1;
    drive_req(0, 1'b0, 0, 0, 0);
    wait_rsp("tie_rsp0", 0, 32'hFFFFFFFE, t);
    check("tie_b2b_ready1", o_req1_ready, 1);
    @(posedge i_clk_n); #1;
    drive_req(1, 1'b0, 0, 0, 0);
    wait_rsp("tie_rsp1", 1, 32'hFFFFFFFE, t);
    @(posedge i_clk_n); #1;
    drive_req(0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011);
    drive_req(1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011);
    @(negedge i_clk_n);
    check("tie2_ready0", o_req0_ready, 1);
    check("tie2_ready1", o_req1_ready, 0);
    @(posedge i_clk_n); #1;
    drive_req(0, 1'b0, 0, 0, 0);
    drive_req(1, 1'b0, 0, 0, 0);
    wait_rsp("tie2_rsp0", 0, 32'hFFFFFFFE, t);

    // DIVU 100/7 with enable-width count.
    send("divu", 0, 32'd100, 32'd7, 3'b101, acc);
    encount = 0; got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge i_clk_n);
      if (o_md_en) encount++;
      if (o_rsp0_valid) begin
        got = 1;
        check("divu_result", o_rsp0_result, 32'd14);
      end
    end
    check("divu_rsp_seen", got, 1);
    check("divu_en_cycles", encount, EN);

    send("rem", 1, 32'hFFFFFFF9, 32'd2, 3'b110, acc);
    wait_rsp("rem_rsp", 1, 32'hFFFFFFFF, t);

    // Backpressure on port 0's response buffer.
    @(posedge i_clk_n); #1 i_rsp0_ready = 1'b0;
    send("bp_mul", 0, 32'd3, 32'd5, 3'b000, acc);
    wait_rsp("bp_rsp0", 0, 32'd15, t);
    @(posedge i_clk_n); #1;
    drive_req(0, 1'b1, 32'd2, 32'd2, 3'b000);
    drive_req(1, 1'b1, 32'd4, 32'd4, 3'b000);
    seen = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge i_clk_n);
      if (o_req0_ready) seen = 1;
      if (o_req1_ready) got = 1;
    end
    check("bp_port1_accepted", got, 1);
    check("bp_port0_blocked", seen, 0);
    @(posedge i_clk_n); #1;
    drive_req(1, 1'b0, 0, 0, 0);
    wait_rsp("bp_rsp1", 1, 32'd16, t);
    check("bp_rsp0_held", o_rsp0_valid, 1);
    @(posedge i_clk_n); #1 i_rsp0_ready = 1'b1;
    @(negedge i_clk_n);
    check("bp_drain_cycle_ready0", o_req0_ready, 0);
    @(negedge i_clk_n);
    check("bp_after_drain_ready0", o_req0_ready, 1);
    @(posedge i_clk_n); #1;
    drive_req(0, 1'b0, 0, 0, 0);
    wait_rsp("bp_rsp0b", 0, 32'd4, t);

    // MUL with B=0 at minimum latency.
    send("mulz", 0, 32'd1234, 32'd0, 3'b000, acc);
    wait_rsp("mulz_rsp", 0, 32'd0, t);
    check("mulz_latency", t - acc, EN + 2);
    check("mulz_idle", o_busy, 0);

    // Reset during a divide's WAIT.
    send("rst_div", 1, 32'd1000, 32'd7, 3'b101, acc);
    repeat (EN + 4) @(negedge i_clk_n);
    check("rst_div_in_wait", o_busy, 1);
    @(posedge i_clk_n); #1 i_rst = 1'b1;
    @(posedge i_clk_n); #1 i_rst = 1'b0;
    @(negedge i_clk_n);
    check("mrst_md_a", o_md_a, 0);
    check("mrst_md_b", o_md_b, 0);
    check("mrst_md_funct3", o_md_funct3, 0);
    check("mrst_md_en", o_md_en, 0);
    check("mrst_busy", o_busy, 0);
    check("mrst_rsp0_result", o_rsp0_result, 0);
    seen = 0;
    repeat (40) begin
      @(negedge i_clk_n);
      if (o_rsp1_valid) seen = 1;
    end
    check("mrst_no_rsp1", seen, 0);
    send("divu93", 0, 32'd9, 32'd3, 3'b101, acc);
    wait_rsp("divu93_rsp", 0, 32'd3, t);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge i_clk_n); #1;
      drive_req(0, $urandom_range(0, 2) != 0, rnd_op(), rnd_op(), 3'($urandom_range(0, 7)));
      drive_req(1, $urandom_range(0, 2) != 0, rnd_op(), rnd_op(), 3'($urandom_range(0, 7)));
      i_rsp0_ready = ($urandom_range(0, 3) != 0);
      i_rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge i_clk_n); #1;
    drive_req(0, 1'b0, 0, 0, 0);
    drive_req(1, 1'b0, 0, 0, 0);
    i_rsp0_ready = 1'b1;
    i_rsp1_ready = 1'b1;
    repeat (60) @(negedge i_clk_n);
    check("end_idle", o_busy, 0);
    check("end_rsp0_empty", o_rsp0_valid, 0);
    check("end_rsp1_empty", o_rsp1_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
